// File: rtl/matrix_dot_scheduler_if.sv
// rtl/matrix_dot_scheduler_if.sv - loader read ports and result stream of the dot scheduler
interface matrix_dot_scheduler_if #(
    parameter int W = 8,
    parameter int N = 32,
    parameter int M = 32
);
    localparam int AW = $clog2(N);
    localparam int BW = $clog2(M);
    localparam int SW = 2 * W + AW;

    logic [AW-1:0]  requested_a_row;
    logic [BW-1:0]  requested_b_col;
    logic [AW-1:0]  a_addr_in;
    logic [BW-1:0]  b_addr_in;
    logic [N*W-1:0] a_row_in;
    logic [N*W-1:0] b_col_in;
    logic           c_valid;
    logic           c_ready;
    logic [AW-1:0]  c_row;
    logic [BW-1:0]  c_col;
    logic [SW-1:0]  c_data;

    modport master (
        output requested_a_row, requested_b_col, c_valid, c_row, c_col, c_data,
        input  a_addr_in, b_addr_in, a_row_in, b_col_in, c_ready
    );

    modport slave (
        input  requested_a_row, requested_b_col, c_valid, c_row, c_col, c_data,
        output a_addr_in, b_addr_in, a_row_in, b_col_in, c_ready
    );
endinterface

// File: rtl/matrix_dot_scheduler.sv
// rtl/matrix_dot_scheduler.sv - walks C = A*B row-major, fetching tagged vectors and MACing them
module matrix_dot_scheduler #(
    parameter int MAX_ELEMENT_SIZE = 8,
    parameter int MAX_SIZE_A       = 32,
    parameter int MAX_SIZE_B       = 32,
    parameter int READ_LATENCY     = 3,
    parameter int LANES            = 4
) (
    input  logic inter_refclk,
    input  logic rst,
    input  logic start,
    matrix_dot_scheduler_if.master bus,
    output logic busy,
    output logic done,
    output logic tag_error
);
    localparam int W     = MAX_ELEMENT_SIZE;
    localparam int N     = MAX_SIZE_A;
    localparam int M     = MAX_SIZE_B;
    localparam int AW    = $clog2(N);
    localparam int BW    = $clog2(M);
    localparam int SW    = 2 * W + AW;
    localparam int STEPS = N / LANES;
    localparam int SCW   = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int RLW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, MAC, OUTPUT} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  i_q, i_d, req_a_q, req_a_d;
    logic [BW-1:0]  j_q, j_d, req_b_q, req_b_d;
    logic [RLW-1:0] wait_q, wait_d;
    logic [SCW-1:0] step_q, step_d;
    logic [N*W-1:0] a_vec_q, a_vec_d, b_vec_q, b_vec_d;
    logic [SW-1:0]  acc_q, acc_d, lane_sum;
    logic           busy_q, busy_d, done_q, done_d, tag_err_q, tag_err_d;

    // Vectors shift left each MAC cycle so the active lanes are always the top LANES elements.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + SW'(a_vec_q[N*W-1-l*W -: W]) * SW'(b_vec_q[N*W-1-l*W -: W]);
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        req_a_d   = req_a_q;
        req_b_d   = req_b_q;
        wait_d    = wait_q;
        step_d    = step_q;
        a_vec_d   = a_vec_q;
        b_vec_d   = b_vec_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tag_err_d = tag_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                req_a_d = i_q;
                req_b_d = j_q;
                wait_d  = RLW'(READ_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else if (bus.a_addr_in == i_q && bus.b_addr_in == j_q) begin
                    a_vec_d = bus.a_row_in;
                    b_vec_d = bus.b_col_in;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = MAC;
                end else begin
                    tag_err_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            MAC: begin
                acc_d   = acc_q + lane_sum;
                a_vec_d = a_vec_q << (LANES * W);
                b_vec_d = b_vec_q << (LANES * W);
                step_d  = step_q + 1'b1;
                if (step_q == SCW'(STEPS - 1)) state_d = OUTPUT;
            end
            OUTPUT: begin
                if (bus.c_ready) begin
                    state_d = ISSUE;
                    if (j_q == BW'(M - 1)) begin
                        j_d = '0;
                        if (i_q == AW'(N - 1)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            req_a_q   <= '0;
            req_b_q   <= '0;
            wait_q    <= '0;
            step_q    <= '0;
            a_vec_q   <= '0;
            b_vec_q   <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tag_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            req_a_q   <= req_a_d;
            req_b_q   <= req_b_d;
            wait_q    <= wait_d;
            step_q    <= step_d;
            a_vec_q   <= a_vec_d;
            b_vec_q   <= b_vec_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tag_err_q <= tag_err_d;
        end
    end

    // The request is visible during ISSUE itself, then held until the next ISSUE.
    assign bus.requested_a_row = (state_q == ISSUE) ? i_q : req_a_q;
    assign bus.requested_b_col = (state_q == ISSUE) ? j_q : req_b_q;
    assign bus.c_valid         = (state_q == OUTPUT);
    assign bus.c_row           = i_q;
    assign bus.c_col           = j_q;
    assign bus.c_data          = acc_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign tag_error           = tag_err_q;
endmodule

// File: tb/tb_matrix_dot_scheduler.sv
// tb/tb_matrix_dot_scheduler.sv - scoreboard bench for matrix_dot_scheduler
module tb_matrix_dot_scheduler;
    localparam int W     = 8;
    localparam int N     = 32;
    localparam int M     = 32;
    localparam int RL    = 3;
    localparam int LANES = 4;

    typedef struct {
        int i;
        int j;
        int d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, tag_error;
    int   cyc = 0;

    matrix_dot_scheduler_if #(.W(W), .N(N), .M(M)) bus ();

    matrix_dot_scheduler #(
        .MAX_ELEMENT_SIZE(W), .MAX_SIZE_A(N), .MAX_SIZE_B(M),
        .READ_LATENCY(RL), .LANES(LANES)
    ) dut (
        .inter_refclk(clk), .rst(rst), .start(start), .bus(bus.master),
        .busy(busy), .done(done), .tag_error(tag_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   mode = 0;
    bit   rand_ready = 1'b0;
    bit   inject_armed = 1'b0;

    function automatic int a_elem(int md, int i, int k);
        case (md)
            0: return 1;
            1: return (i == k) ? 1 : 0;
            2: return 255;
            default: return i;
        endcase
    endfunction

    function automatic int b_elem(int md, int k, int j);
        case (md)
            0: return 1;
            1: return j;
            2: return 255;
            default: return k;
        endcase
    endfunction

    // Hand-derived closed forms for each pattern.
    function automatic int exp_c(int md, int i, int j);
        case (md)
            0: return 32;
            1: return j;
            2: return 2080800;
            default: return i * 496;
        endcase
    endfunction

    function automatic logic [N*W-1:0] a_vec(int md, int i);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[N*W-1-k*W -: W] = W'(a_elem(md, i, k));
        return v;
    endfunction

    function automatic logic [N*W-1:0] b_vec(int md, int j);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[N*W-1-k*W -: W] = W'(b_elem(md, k, j));
        return v;
    endfunction

    task automatic check(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic push_run(int md, int count);
        exp_t e;
        for (int idx = 0; idx < count; idx++) begin
            e.i = idx / M;
            e.j = idx % M;
            e.d = exp_c(md, e.i, e.j);
            sb.push_back(e);
        end
    endtask

    // Loader model: data for a request seen in cycle t is presented from cycle t+RL.
    int pa[RL+1];
    int pb[RL+1];
    initial begin
        for (int s = 0; s <= RL; s++) begin
            pa[s] = 0;
            pb[s] = 0;
        end
        bus.a_addr_in = '0;
        bus.b_addr_in = '0;
        bus.a_row_in  = '0;
        bus.b_col_in  = '0;
        forever begin
            @(negedge clk);
            for (int s = RL; s > 0; s--) begin
                pa[s] = pa[s-1];
                pb[s] = pb[s-1];
            end
            pa[0] = int'(bus.requested_a_row);
            pb[0] = int'(bus.requested_b_col);
            bus.a_addr_in = $clog2(N)'(pa[RL]);
            bus.a_row_in  = a_vec(mode, pa[RL]);
            bus.b_col_in  = b_vec(mode, pb[RL]);
            if (inject_armed && pa[RL] == 5 && pb[RL] == 7) begin
                bus.b_addr_in = $clog2(M)'(pb[RL] + 1);
                inject_armed  = 1'b0;
            end else begin
                bus.b_addr_in = $clog2(M)'(pb[RL]);
            end
        end
    end

    initial begin
        bus.c_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.c_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin
        bit   prev_stall = 1'b0;
        int   pr, pc, pd;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (prev_stall && !rst) begin
                n_cmp++;
                if (!bus.c_valid || int'(bus.c_row) != pr || int'(bus.c_col) != pc || int'(bus.c_data) != pd) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%0b (%0d,%0d)=%0d expected v=1 (%0d,%0d)=%0d",
                             bus.c_valid, bus.c_row, bus.c_col, bus.c_data, pr, pc, pd);
                end
            end
            if (bus.c_valid && bus.c_ready && !rst) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL result_extra: got (%0d,%0d)=%0d expected no result",
                             bus.c_row, bus.c_col, bus.c_data);
                end else begin
                    e = sb.pop_front();
                    if (int'(bus.c_row) != e.i || int'(bus.c_col) != e.j || int'(bus.c_data) != e.d) begin
                        n_fail++;
                        $display("FAIL result: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                                 bus.c_row, bus.c_col, bus.c_data, e.i, e.j, e.d);
                    end
                end
            end
            prev_stall = bus.c_valid && !bus.c_ready && !rst;
            pr = int'(bus.c_row);
            pc = int'(bus.c_col);
            pd = int'(bus.c_data);
        end
    end

    task automatic pulse_start(output int s);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done(int s, int limit, output int delta);
        delta = -1;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (done) begin
                delta = cyc - s;
                break;
            end
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_tag_error"}, int'(tag_error), 0);
        check({tag, "_c_valid"}, int'(bus.c_valid), 0);
        check({tag, "_req_a"}, int'(bus.requested_a_row), 0);
        check({tag, "_req_b"}, int'(bus.requested_b_col), 0);
        check({tag, "_c_row"}, int'(bus.c_row), 0);
        check({tag, "_c_col"}, int'(bus.c_col), 0);
        check({tag, "_c_data"}, int'(bus.c_data), 0);
    endtask

    initial begin
        int s, d, fv;
        bit found;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Run A: all ones, first-result latency, full-run length, extra start ignored.
        mode = 0;
        push_run(0, N * M);
        pulse_start(s);
        fv = -1;
        for (int c = 0; c < 100; c++) begin
            if (bus.c_valid) begin
                fv = cyc - s;
                break;
            end
            @(negedge clk);
        end
        check("first_valid_latency", fv, 12);
        check("busy_running", int'(busy), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(s, 20000, d);
        check("done_latency_ones", d, 13312);
        check("busy_at_done", int'(busy), 0);
        check("queue_empty_ones", sb.size(), 0);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);

        // Run B: identity x column-constant, one tag mismatch on (5,7).
        mode = 1;
        inject_armed = 1'b1;
        check("tag_error_clear", int'(tag_error), 0);
        push_run(1, N * M);
        pulse_start(s);
        wait_done(s, 20000, d);
        check("done_latency_retry", d, 13312 + 1 + RL);
        check("tag_error_set", int'(tag_error), 1);
        check("queue_empty_ident", sb.size(), 0);

        // Run C: all 255, full-width result.
        mode = 2;
        push_run(2, N * M);
        pulse_start(s);
        wait_done(s, 20000, d);
        check("done_latency_255", d, 13312);
        check("queue_empty_255", sb.size(), 0);
        check("tag_error_sticky", int'(tag_error), 1);

        // Run D: A[i][k]=i, B[k][j]=k with random backpressure.
        mode = 3;
        rand_ready = 1'b1;
        push_run(3, N * M);
        pulse_start(s);
        wait_done(s, 40000, d);
        n_cmp++;
        if (d < 13312) begin
            n_fail++;
            $display("FAIL done_random: got %0d expected at least 13312", d);
        end
        check("queue_empty_random", sb.size(), 0);
        rand_ready = 1'b0;

        // Run E: reset during MAC of (3,3), then restart from (0,0).
        mode = 0;
        push_run(0, 3 * M + 3);
        pulse_start(s);
        found = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (int'(bus.requested_a_row) == 3 && int'(bus.requested_b_col) == 3) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_3_3", int'(found), 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_rst");
        check("queue_empty_abort", sb.size(), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        check("start_with_rst_busy", int'(busy), 0);
        @(negedge clk);
        check("idle_after_rst", int'(busy), 0);
        push_run(0, 2);
        pulse_start(s);
        for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk);
        check("restart_results", sb.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
